// File: rtl/irq_priority_latch.sv
// irq_priority_latch
//   Captures request events into a pending register. Selects the highest-index
//   eligible (pending & mask) source and offers it as a registered index on a
//   valid/ready handshake. The pending bit of a source is cleared on the edge
//   where that source is captured into irq_idx.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_in     request lines (N_SRC), synchronous to clk
//   mask       per-source eligibility (1 = may be selected)
//   irq_ready  consumer accepts irq_idx this cycle
//   ovf_clr    clears the sticky overflow register
//   irq_valid  irq_idx holds a granted source
//   irq_idx    index of the granted source
//   pending    latched requests not yet granted
//   overflow   sticky: event arrived while the same source was still pending
module irq_priority_latch #(
  parameter int N_SRC = 8,
  parameter int IDX_W = 3,
  parameter int EDGE  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] req_in,
  input  logic [N_SRC-1:0] mask,
  input  logic             irq_ready,
  input  logic             ovf_clr,
  output logic             irq_valid,
  output logic [IDX_W-1:0] irq_idx,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] overflow
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] OFFER = 1'b1;

  logic [0:0]       state_q,    state_d;
  logic [N_SRC-1:0] pending_q,  pending_d;
  logic [N_SRC-1:0] req_d_q,    req_d_d;
  logic [N_SRC-1:0] overflow_q, overflow_d;
  logic [IDX_W-1:0] irq_idx_q,  irq_idx_d;

  logic [N_SRC-1:0] ev;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] cap_mask;
  logic [IDX_W-1:0] sel;
  logic             capture;

  // Event detection and priority selection
  always_comb begin
    if (EDGE != 0) begin
      ev = req_in & ~req_d_q;
    end else begin
      ev = req_in;
    end
    eligible = pending_q & mask;
    sel      = '0;
    // Ascending scan: the last hit is the highest set index.
    for (int i = 0; i < N_SRC; i++) begin
      if (eligible[i]) begin
        sel = IDX_W'(i);
      end
    end
  end

  // Grant control and next-state computation
  always_comb begin
    state_d   = state_q;
    irq_idx_d = irq_idx_q;
    capture   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|eligible) begin
          capture = 1'b1;
          state_d = OFFER;
        end
      end
      default: begin
        // Held stable until accepted; no re-arbitration while stalled.
        if (irq_ready) begin
          if (|eligible) begin
            capture = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase
    if (capture) begin
      irq_idx_d = sel;
    end

    cap_mask = capture ? (N_SRC'(1) << sel) : '0;

    // A new event on the captured bit re-arms it (set wins over capture-clear).
    pending_d = (pending_q & ~cap_mask) | ev;

    req_d_d = req_in;

    // A set on the same edge as ovf_clr wins.
    if (EDGE != 0) begin
      overflow_d = (ovf_clr ? '0 : overflow_q) | (ev & pending_q & ~cap_mask);
    end else begin
      overflow_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      req_d_q    <= '0;
      overflow_q <= '0;
      irq_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      req_d_q    <= req_d_d;
      overflow_q <= overflow_d;
      irq_idx_q  <= irq_idx_d;
    end
  end

  assign irq_valid = (state_q == OFFER);
  assign irq_idx   = irq_idx_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_irq_priority_latch.sv
// Testbench for irq_priority_latch: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// behavioural model of the grant/pending/overflow rules.
module tb_irq_priority_latch;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req_in = '0;
  logic [N-1:0] mask = 8'hFF;
  logic         irq_ready = 1'b0;
  logic         ovf_clr = 1'b0;
  logic         irq_valid;
  logic [2:0]   irq_idx;
  logic [N-1:0] pending;
  logic [N-1:0] overflow;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  irq_priority_latch #(.N_SRC(8), .IDX_W(3), .EDGE(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_in    (req_in),
    .mask      (mask),
    .irq_ready (irq_ready),
    .ovf_clr   (ovf_clr),
    .irq_valid (irq_valid),
    .irq_idx   (irq_idx),
    .pending   (pending),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the grant holder, per-source pending/overflow flags and
  // the previous request sample.
  logic [N-1:0] m_pend, m_ovf, m_prev;
  logic         m_valid;
  logic [2:0]   m_idx;

  always @(posedge clk or negedge rst_n) begin : model
    int           hi;
    bit           take;
    bit           cap;
    logic [N-1:0] ev, np, no;
    if (!rst_n) begin
      m_pend  <= '0;
      m_ovf   <= '0;
      m_prev  <= '0;
      m_valid <= 1'b0;
      m_idx   <= '0;
    end else begin
      hi = -1;
      for (int i = 0; i < N; i++) begin
        ev[i] = req_in[i] && !m_prev[i];
        if (m_pend[i] && mask[i]) hi = i;
      end
      // A new grant is taken when nothing is offered or the offer is accepted.
      take = (hi >= 0) && (!m_valid || irq_ready);
      for (int i = 0; i < N; i++) begin
        cap   = take && (i == hi);
        no[i] = (ev[i] && m_pend[i] && !cap) || (m_ovf[i] && !ovf_clr);
        np[i] = ev[i] || (m_pend[i] && !cap);
      end
      m_pend <= np;
      m_ovf  <= no;
      m_prev <= req_in;
      if (take) begin
        m_valid <= 1'b1;
        m_idx   <= 3'(hi);
      end else if (m_valid && irq_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("valid_vs_model", 32'(irq_valid), 32'(m_valid));
      chk("idx_vs_model", 32'(irq_idx), 32'(m_idx));
      chk("pending_vs_model", 32'(pending), 32'(m_pend));
      chk("overflow_vs_model", 32'(overflow), 32'(m_ovf));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_valid", 32'(irq_valid), 32'd0);
    chk("rst_idx", 32'(irq_idx), 32'd0);
    chk("rst_pending", 32'(pending), 32'h00);
    chk("rst_overflow", 32'(overflow), 32'h00);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    tick();

    // 1: two sources, stalled offer, then two accepts
    req_in = 8'h24; tick();
    chk("t1_pend_latched", 32'(pending), 32'h24);
    chk("t1_valid_lat", 32'(irq_valid), 32'd0);
    tick();
    chk("t1_valid", 32'(irq_valid), 32'd1);
    chk("t1_idx5", 32'(irq_idx), 32'd5);
    chk("t1_pend04", 32'(pending), 32'h04);
    tick(); chk("t1_hold1", 32'(irq_idx), 32'd5);
    tick(); chk("t1_hold2", 32'(irq_idx), 32'd5);
    irq_ready = 1'b1; tick();
    chk("t1_idx2", 32'(irq_idx), 32'd2);
    chk("t1_pend0", 32'(pending), 32'h00);
    chk("t1_valid2", 32'(irq_valid), 32'd1);
    tick();
    chk("t1_idle", 32'(irq_valid), 32'd0);
    chk("t1_idx_kept", 32'(irq_idx), 32'd2);
    irq_ready = 1'b0; req_in = 8'h00; tick();

    // 2: back-to-back grants 7, 3, 0
    irq_ready = 1'b1; req_in = 8'h89; tick();
    chk("t2_pend", 32'(pending), 32'h89);
    chk("t2_ready_ignored", 32'(irq_valid), 32'd0);
    tick(); chk("t2_idx7", 32'(irq_idx), 32'd7);
    tick(); chk("t2_idx3", 32'(irq_idx), 32'd3);
    tick(); chk("t2_idx0", 32'(irq_idx), 32'd0);
    chk("t2_valid", 32'(irq_valid), 32'd1);
    tick(); chk("t2_idle", 32'(irq_valid), 32'd0);
    irq_ready = 1'b0; req_in = 8'h00; tick();

    // 3: masked source latches but is not selected until unmasked
    mask = 8'hBF; req_in = 8'h40; tick();
    chk("t3_pend", 32'(pending), 32'h40);
    tick();
    chk("t3_masked", 32'(irq_valid), 32'd0);
    mask = 8'hFF; tick();
    chk("t3_valid", 32'(irq_valid), 32'd1);
    chk("t3_idx6", 32'(irq_idx), 32'd6);
    irq_ready = 1'b1; tick();
    irq_ready = 1'b0; req_in = 8'h00; tick();

    // 4: overflow while a grant for 7 is stalled
    req_in = 8'h80; tick(); tick();
    chk("t4_idx7", 32'(irq_idx), 32'd7);
    req_in = 8'h90; tick();
    chk("t4_no_ovf", 32'(overflow), 32'h00);
    req_in = 8'h80; tick();
    req_in = 8'h90; tick();
    chk("t4_ovf", 32'(overflow), 32'h10);
    chk("t4_pend4", 32'(pending), 32'h10);
    ovf_clr = 1'b1; tick();
    chk("t4_ovf_clr", 32'(overflow), 32'h00);
    ovf_clr = 1'b0; req_in = 8'h80; tick();
    req_in = 8'h90; ovf_clr = 1'b1; tick();
    chk("t4_set_wins", 32'(overflow), 32'h10);
    ovf_clr = 1'b1; req_in = 8'h00; irq_ready = 1'b1; tick();
    ovf_clr = 1'b0; tick(); tick();
    chk("t4_drained", 32'(irq_valid), 32'd0);
    irq_ready = 1'b0; tick();

    // 5: event on bit 3 on the same edge bit 3 is captured
    req_in = 8'h80; tick(); tick();
    req_in = 8'h88; tick();
    req_in = 8'h80; tick();
    irq_ready = 1'b1; req_in = 8'h88; tick();
    chk("t5_idx3", 32'(irq_idx), 32'd3);
    chk("t5_pend_kept", 32'(pending), 32'h08);
    chk("t5_no_ovf", 32'(overflow), 32'h00);
    tick();
    chk("t5_regrant", 32'(irq_idx), 32'd3);
    chk("t5_valid", 32'(irq_valid), 32'd1);
    chk("t5_pend0", 32'(pending), 32'h00);
    tick();
    irq_ready = 1'b0; req_in = 8'h00; tick();

    // 6: asynchronous reset while offering with pending 81
    req_in = 8'h81; tick(); tick();
    req_in = 8'h01; tick();
    req_in = 8'h81; tick();
    chk("t6_pre_valid", 32'(irq_valid), 32'd1);
    chk("t6_pre_pend", 32'(pending), 32'h81);
    req_in = 8'h01;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(irq_valid), 32'd0);
    chk("t6_async_pend", 32'(pending), 32'h00);
    chk("t6_async_ovf", 32'(overflow), 32'h00);
    tick(); tick();
    rst_n = 1'b1; tick();
    chk("t6_first_ev", 32'(pending), 32'h01);
    chk("t6_not_yet", 32'(irq_valid), 32'd0);
    tick();
    chk("t6_valid", 32'(irq_valid), 32'd1);
    chk("t6_idx0", 32'(irq_idx), 32'd0);
    irq_ready = 1'b1; tick();
    irq_ready = 1'b0; req_in = 8'h00; tick();

    // Randomized traffic, checked every cycle by the compare process
    for (int c = 0; c < 3000; c++) begin
      req_in    = 8'($urandom & $urandom);
      mask      = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      irq_ready = ($urandom_range(0, 2) != 0);
      ovf_clr   = ($urandom_range(0, 7) == 0);
      if (c == 1500) begin
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
